// File: rtl/uart_pkg.sv
// Shared constants, state encodings and parity helper
// for the parametrised UART transceiver.
package uart_pkg;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_ODD    = 1;
  localparam int PARITY_EVEN   = 2;
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Even parity is the plain XOR; odd parity is its inverse.
  function automatic logic parity_bit(
    input logic [MAX_DATA_BITS-1:0] data,
    input int                       mode
  );
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

  function automatic bit has_parity(input int mode);
    return (mode == PARITY_ODD) || (mode == PARITY_EVEN);
  endfunction

endpackage

// File: rtl/uart_xcvr_param_if.sv
// Parallel-side bundle of the UART transceiver:
// transmit handshake plus received-frame results.
interface uart_xcvr_param_if #(
  parameter int DATA_BITS = 8
);

  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_done;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 framing_err;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  tx_done,
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  framing_err
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output tx_done,
    output rx_data,
    output rx_valid,
    output parity_err,
    output framing_err
  );

endinterface

// File: rtl/uart_rx_path.sv
// UART receive path: 2-flop synchroniser, mid-bit
// sampling state machine and parity/framing flags.
module uart_rx_path
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 line,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 framing_err
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST =
    BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST =
    BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST =
    BIT_W'(DATA_BITS - 1);
  localparam bit HAS_PAR = has_parity(PARITY);

  logic                 sync1;
  logic                 sync2;
  rx_state_e            state;
  rx_state_e            state_d;
  logic [BAUD_W-1:0]    baud;
  logic [BAUD_W-1:0]    baud_d;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_cnt_d;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_d;
  logic                 par;
  logic                 par_d;
  logic                 bit_end;
  logic                 done;

  assign bit_end = (baud == BAUD_LAST);

  always_comb begin
    state_d   = state;
    baud_d    = bit_end ? '0 : baud + BAUD_W'(1);
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    par_d     = par;
    done      = 1'b0;
    unique case (state)
      RX_IDLE: begin
        baud_d    = '0;
        bit_cnt_d = '0;
        if (!sync2) state_d = RX_START;
      end
      RX_START: begin
        // A start bit that is high again at mid-bit is a glitch.
        if (baud == HALF_LAST) begin
          baud_d  = '0;
          state_d = sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          shift_d   = {sync2, shift[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt + BIT_W'(1);
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = HAS_PAR ? RX_PARITY : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (bit_end) begin
          par_d   = sync2;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bit_end) begin
          done    = 1'b1;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      state       <= RX_IDLE;
      baud        <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      par         <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      sync1    <= line;
      sync2    <= sync1;
      state    <= state_d;
      baud     <= baud_d;
      bit_cnt  <= bit_cnt_d;
      shift    <= shift_d;
      par      <= par_d;
      rx_valid <= done;
      if (done) begin
        rx_data     <= shift;
        parity_err  <= HAS_PAR &&
          (parity_bit(MAX_DATA_BITS'(shift), PARITY) != par);
        framing_err <= !sync2;
      end
    end
  end

endmodule

// File: rtl/uart_xcvr_param.sv
// Parametrised full-duplex UART: transmit state machine,
// loopback mux and the receive path instance.
module uart_xcvr_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loopback,
  output logic             tx,
  input  logic             rx,
  uart_xcvr_param_if.slave bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST =
    BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST =
    BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST =
    BIT_W'(STOP_BITS - 1);
  localparam bit HAS_PAR = has_parity(PARITY);

  tx_state_e            state;
  tx_state_e            state_d;
  logic [BAUD_W-1:0]    baud;
  logic [BAUD_W-1:0]    baud_d;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_cnt_d;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_d;
  logic                 par;
  logic                 par_d;
  logic                 bit_end;
  logic                 line;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 framing_err;

  assign bit_end      = (baud == BAUD_LAST);
  assign bus.tx_ready = (state == TX_IDLE);
  assign bus.tx_done  = (state == TX_STOP) && bit_end &&
                        (bit_cnt == STOP_LAST);

  always_comb begin
    state_d   = state;
    baud_d    = bit_end ? '0 : baud + BAUD_W'(1);
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    par_d     = par;
    tx        = 1'b1;
    unique case (state)
      TX_IDLE: begin
        baud_d    = '0;
        bit_cnt_d = '0;
        if (bus.tx_valid) begin
          state_d = TX_START;
          shift_d = bus.tx_data;
          par_d   = parity_bit(
            MAX_DATA_BITS'(bus.tx_data), PARITY);
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (bit_end) state_d = TX_DATA;
      end
      TX_DATA: begin
        tx = shift[0];
        if (bit_end) begin
          shift_d   = shift >> 1;
          bit_cnt_d = bit_cnt + BIT_W'(1);
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = HAS_PAR ? TX_PARITY : TX_STOP;
          end
        end
      end
      TX_PARITY: begin
        tx = par;
        if (bit_end) state_d = TX_STOP;
      end
      TX_STOP: begin
        // bit_cnt is reused to count stop bits.
        if (bit_end) begin
          bit_cnt_d = bit_cnt + BIT_W'(1);
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_cnt <= bit_cnt_d;
      shift   <= shift_d;
      par     <= par_d;
    end
  end

  assign line = loopback ? tx : rx;

  uart_rx_path #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS),
    .PARITY       (PARITY)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .line        (line),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .framing_err (framing_err)
  );

  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.parity_err  = parity_err;
  assign bus.framing_err = framing_err;

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Bench for uart_xcvr_param: three configurations (8N1, 8E1, 7N2)
// checked against a frame-level reference model.
module tb_uart_xcvr_param;

  localparam int BIT = 16;
  localparam int CAP = 200;

  logic       clk;
  logic       rst;
  logic       loopback;
  logic       rx_pin;
  logic       tx_valid;
  logic [8:0] tx_data;
  logic       tx_a, tx_b, tx_c;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int rxv_n [3];
  int done_n [3];
  int done_at [3];
  int txbad [3];
  int rdybad [3];
  logic [8:0] rxd_l [3];
  logic       pe_l [3];
  logic       fe_l [3];

  logic [2:0] tx_s, rdy_s, done_s, rxv_s, pe_s, fe_s;
  logic [8:0] rxd_s [3];

  uart_xcvr_param_if #(.DATA_BITS(8)) ia ();
  uart_xcvr_param_if #(.DATA_BITS(8)) ib ();
  uart_xcvr_param_if #(.DATA_BITS(7)) ic ();

  uart_xcvr_param #(
    .CLKS_PER_BIT(BIT), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .loopback(loopback),
    .tx(tx_a), .rx(rx_pin), .bus(ia)
  );

  uart_xcvr_param #(
    .CLKS_PER_BIT(BIT), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) dut_b (
    .clk(clk), .rst(rst), .loopback(loopback),
    .tx(tx_b), .rx(rx_pin), .bus(ib)
  );

  uart_xcvr_param #(
    .CLKS_PER_BIT(BIT), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)
  ) dut_c (
    .clk(clk), .rst(rst), .loopback(loopback),
    .tx(tx_c), .rx(rx_pin), .bus(ic)
  );

  assign ia.tx_valid = tx_valid;
  assign ib.tx_valid = tx_valid;
  assign ic.tx_valid = tx_valid;
  assign ia.tx_data  = tx_data[7:0];
  assign ib.tx_data  = tx_data[7:0];
  assign ic.tx_data  = tx_data[6:0];

  assign tx_s   = {tx_c, tx_b, tx_a};
  assign rdy_s  = {ic.tx_ready, ib.tx_ready, ia.tx_ready};
  assign done_s = {ic.tx_done, ib.tx_done, ia.tx_done};
  assign rxv_s  = {ic.rx_valid, ib.rx_valid, ia.rx_valid};
  assign pe_s   = {ic.parity_err, ib.parity_err, ia.parity_err};
  assign fe_s   = {ic.framing_err, ib.framing_err, ia.framing_err};
  assign rxd_s[0] = {1'b0, ia.rx_data};
  assign rxd_s[1] = {1'b0, ib.rx_data};
  assign rxd_s[2] = {2'b00, ic.rx_data};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-configuration frame layout.
  function automatic int dbits(int i);
    return (i == 2) ? 7 : 8;
  endfunction

  function automatic int pmode(int i);
    return (i == 1) ? 2 : 0;
  endfunction

  function automatic int sbits(int i);
    return (i == 2) ? 2 : 1;
  endfunction

  function automatic int flen(int i);
    return 1 + dbits(i) + ((pmode(i) != 0) ? 1 : 0) + sbits(i);
  endfunction

  function automatic logic [8:0] dmask(int i, logic [8:0] d);
    return d & ((9'h1 << dbits(i)) - 9'h1);
  endfunction

  function automatic logic [15:0] frame(int i, logic [8:0] d);
    logic [15:0] f;
    logic [8:0]  m;
    int          ones;
    f    = '1;
    m    = dmask(i, d);
    f[0] = 1'b0;
    for (int b = 0; b < dbits(i); b++) f[1 + b] = m[b];
    ones = $countones(m);
    if (pmode(i) == 2) f[1 + dbits(i)] = ones[0];
    if (pmode(i) == 1) f[1 + dbits(i)] = ~ones[0];
    return f;
  endfunction

  function automatic logic exp_tx(int i, logic [8:0] d, int k);
    logic [15:0] f;
    f = frame(i, d);
    if (k < 1 || k > flen(i) * BIT) return 1'b1;
    return f[(k - 1) / BIT];
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_rec();
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      rxv_n[i]   = 0;
      done_n[i]  = 0;
      done_at[i] = 0;
      txbad[i]   = 0;
      rdybad[i]  = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rxv_s[i] === 1'b1) begin
        rxv_n[i]++;
        rxd_l[i] = rxd_s[i];
        pe_l[i]  = pe_s[i];
        fe_l[i]  = fe_s[i];
      end
      if (done_s[i] === 1'b1) begin
        done_n[i]++;
        if (done_at[i] == 0) done_at[i] = cyc;
      end
    end
  endtask

  task automatic send(input logic [8:0] d,
                      input int mid_at,
                      input int rst_at);
    int w;
    w = 0;
    while (rdy_s !== 3'b111 && w < 1000) begin
      tick();
      w++;
    end
    chk("ready_wait", 32'(w < 1000), 1);
    clear_rec();
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    while (cyc < CAP) begin
      for (int i = 0; i < 3; i++) begin
        if (rst_at == 0) begin
          if (tx_s[i] !== exp_tx(i, d, cyc)) txbad[i]++;
          if (cyc <= flen(i) * BIT && rdy_s[i] !== 1'b0)
            rdybad[i]++;
          if (cyc == flen(i) * BIT + 1 && rdy_s[i] !== 1'b1)
            rdybad[i]++;
        end
      end
      if (rst_at != 0 && cyc == rst_at + 1) begin
        chk("rst_mid_tx", 32'(tx_s), 32'h7);
        chk("rst_mid_ready", 32'(rdy_s), 32'h7);
        rst = 1'b0;
      end
      if (cyc == rst_at) rst = 1'b1;
      tx_valid = (cyc == mid_at);
      if (cyc == mid_at) tx_data = ~d;
      tick();
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ready_end%0d", i), 32'(rdy_s[i]), 1);
      if (rst_at == 0) begin
        chk($sformatf("tx_wave%0d", i), txbad[i], 0);
        chk($sformatf("ready_busy%0d", i), rdybad[i], 0);
        chk($sformatf("done_at%0d", i), done_at[i], flen(i) * BIT);
        chk($sformatf("done_n%0d", i), done_n[i], 1);
        chk($sformatf("lb_rxv%0d", i), rxv_n[i], 1);
        chk($sformatf("lb_data%0d", i), 32'(rxd_l[i]),
            32'(dmask(i, d)));
        chk($sformatf("lb_perr%0d", i), 32'(pe_l[i]), 0);
        chk($sformatf("lb_ferr%0d", i), 32'(fe_l[i]), 0);
      end else begin
        chk($sformatf("rst_done%0d", i), done_n[i], 0);
        chk($sformatf("rst_rxv%0d", i), rxv_n[i], 0);
      end
    end
  endtask

  task automatic drive_frame(input logic [15:0] f, input int n);
    clear_rec();
    for (int b = 0; b < n; b++) begin
      rx_pin = f[b];
      repeat (BIT) tick();
    end
    rx_pin = 1'b1;
    repeat (40) tick();
  endtask

  task automatic check_rx(input string tag, input int i,
                          input logic [8:0] d,
                          input logic pe, input logic fe);
    chk({tag, "_rxv"}, rxv_n[i], 1);
    chk({tag, "_data"}, 32'(rxd_l[i]), 32'(dmask(i, d)));
    chk({tag, "_perr"}, 32'(pe_l[i]), 32'(pe));
    chk({tag, "_ferr"}, 32'(fe_l[i]), 32'(fe));
  endtask

  initial begin
    logic [15:0] f;
    logic [8:0]  d;
    rst      = 1'b1;
    loopback = 1'b1;
    rx_pin   = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    clear_rec();
    repeat (3) tick();
    chk("reset_tx", 32'(tx_s), 32'h7);
    chk("reset_ready", 32'(rdy_s), 32'h7);
    chk("reset_done", 32'(done_s), 0);
    chk("reset_rxv", 32'(rxv_s), 0);
    chk("reset_perr", 32'(pe_s), 0);
    chk("reset_ferr", 32'(fe_s), 0);
    chk("reset_rxd", 32'({rxd_s[0], rxd_s[1], rxd_s[2]}), 0);
    rst = 1'b0;
    tick();

    send(9'h055, 0, 0);
    send(9'h0A7, 0, 0);
    send(9'h05A, 40, 0);
    send(9'($urandom), 0, 50);
    send(9'h0F0, 0, 0);
    for (int n = 0; n < 4; n++) send(9'($urandom), 0, 0);

    loopback = 1'b0;
    repeat (5) tick();

    f = frame(1, 9'h0A7);
    f[9] = ~f[9];
    drive_frame(f, flen(1));
    check_rx("ext_par", 1, 9'h0A7, 1'b1, 1'b0);

    f = frame(0, 9'h03C);
    f[9] = 1'b0;
    drive_frame(f, flen(0));
    check_rx("ext_frm", 0, 9'h03C, 1'b0, 1'b1);

    drive_frame(frame(0, 9'h081), flen(0));
    check_rx("ext_clean", 0, 9'h081, 1'b0, 1'b0);

    clear_rec();
    rx_pin = 1'b0;
    repeat (5) tick();
    rx_pin = 1'b1;
    repeat (40) tick();
    chk("glitch_rxv", rxv_n[0], 0);

    d = 9'($urandom);
    drive_frame(frame(0, d), flen(0));
    check_rx("post_glitch", 0, d, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_xcvr_param.md
Name: uart_xcvr_param

Overview:
Parametrised full-duplex UART transceiver that succeeds the fixed 8N1 uart_top. It adds configurable data width, parity, stop-bit count and bit period. It also adds a valid/ready transmit handshake, framing/parity error detection, glitch rejection on the receive start bit, and an internal loopback mode. It sits between the system clock domain and the external serial pins.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (434 = 50 MHz / 115200); legal range 4 to 65535.
DATA_BITS, 8, payload bits per frame; legal range 5 to 9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits transmitted; 1 or 2.

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous, active-high reset
loopback  in  1  1 = receiver takes the internal tx line instead of the rx pin
tx_valid  in  1  transmit request
tx_ready  out  1  transmitter idle and able to accept data
tx_data  in  DATA_BITS  transmit payload, sent LSB first
tx  out  1  serial output, idle high
tx_done  out  1  one-cycle pulse at the end of the last stop bit
rx  in  1  serial input, asynchronous
rx_data  out  DATA_BITS  last received payload
rx_valid  out  1  one-cycle pulse when a frame completes
parity_err  out  1  qualifies rx_valid: parity mismatch
framing_err  out  1  qualifies rx_valid: first stop bit sampled low

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: tx=1, tx_ready=1, tx_done=0, rx_data=0, rx_valid=0, parity_err=0, framing_err=0. Both state machines go to IDLE and all counters clear.
- Reset mid-frame: the frame is abandoned. tx is high on the first cycle after rst is sampled, and no partial rx_valid is produced.
- TX state machine: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - Handshake: a transfer occurs when tx_valid && tx_ready on a clock edge. tx_data is latched on that edge and tx_ready drops on that same edge.
  - tx goes low (start bit) on the cycle after the transfer.
  - Bit timing: every bit is held exactly CLKS_PER_BIT cycles. Data goes out LSB first. The parity bit is the XOR of the data bits for even parity and its inverse for odd parity. STOP holds tx high for STOP_BITS*CLKS_PER_BIT cycles.
  - Completion: tx_done pulses on the last cycle of STOP, and tx_ready rises on the next cycle.
  - Frame length: 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bits. tx_valid while tx_ready=0 is ignored and is not queued.
- RX input: rx passes through a 2-flop synchroniser. In loopback, the synchroniser input is tx; the rx pin is ignored and the tx pin still toggles.
- RX state machine: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - IDLE: wait for the synchronised line to be 0.
  - START: wait CLKS_PER_BIT/2 (integer division), then resample. If the line is 1, treat it as a glitch and return to IDLE with no output.
  - DATA, PARITY, STOP: sample every CLKS_PER_BIT cycles after the start mid-point, shifting data in LSB first.
  - STOP: only the first stop bit is checked. After that sample, rx_valid pulses for 1 cycle, and rx_data, parity_err and framing_err update on the same cycle and hold until the next frame. rx_valid fires even when an error flag is set.
  - Return to IDLE happens immediately after the stop sample. A start bit arriving during TX's second stop bit is therefore accepted.
- Independence: TX and RX run fully independently, so simultaneous transmit and receive is required.
- Width rules: the bit counter is $clog2(DATA_BITS+1) wide. The baud counter is $clog2(CLKS_PER_BIT) wide and wraps at CLKS_PER_BIT-1 to 0.

Decomposition:
- uart_pkg holds the PARITY_NONE/ODD/EVEN constants, the TX and RX state enums, and the parity-function helper.
- One sub-module, uart_rx_path, contains the synchroniser, RX state machine and error flags.
- TX logic and the loopback mux stay in uart_xcvr_param.

Test Plan:
1. CLKS_PER_BIT=16, 8N1, loopback=1, send 8'h55 -> tx_done exactly 160 cycles after the transfer edge; rx_valid with rx_data=8'h55 and both error flags 0.
2. PARITY=2 (even), send 8'hA7 (ones=5) -> parity bit on tx = 1; loopback receives 8'hA7 with parity_err=0. Force the external rx parity bit to 0 (loopback=0) -> parity_err=1 on rx_valid.
3. Drive rx with a frame whose stop bit is 0 for data 8'h3C -> rx_valid with rx_data=8'h3C and framing_err=1; the next clean frame 8'h81 clears framing_err.
4. Pulse rx low for 5 cycles (less than 16/2) -> no rx_valid, and the RX state machine returns to IDLE.
5. DATA_BITS=7, STOP_BITS=2, send 7'h5A -> tx line low for 16 cycles, then bits LSB first, then high for 32 cycles; tx_ready=0 throughout; a second tx_valid mid-frame is dropped.
6. Assert rst for 1 cycle at cycle 50 of a frame -> tx=1 and tx_ready=1 the next cycle, no tx_done, no rx_valid; a subsequent 8'hF0 round-trips correctly.
